// File: rtl/prng_lehmer_mc.sv
// prng_lehmer_mc: multi-channel Park-Miller PRNG built on Schrage's method.
// One shared restoring divider and one multiplier pair serve all channel seeds.
module prng_lehmer_mc #(
    parameter int               WIDTH = 32,
    parameter int               NCH   = 4,
    parameter int               CHW   = 2,
    parameter logic [WIDTH-1:0] A_RST = WIDTH'(16807),
    parameter logic [WIDTH-1:0] M_RST = WIDTH'(2147483647)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_wr,
    input  logic [WIDTH-1:0] cfg_m,
    input  logic [WIDTH-1:0] cfg_a,
    input  logic             seed_wr,
    input  logic [CHW-1:0]   seed_ch,
    input  logic [WIDTH-1:0] seed_data,
    input  logic             cont,
    input  logic             req_valid,
    input  logic [CHW-1:0]   req_ch,
    output logic             req_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CHW-1:0]   out_ch,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             seed_fix
);
    typedef enum logic [2:0] {IDLE, CFG_DIV, DIV, MUL, FIX, HOLD} state_t;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH + 2;

    state_t state, state_nx;
    logic [WIDTH-1:0] m, a, q, r, quo, rem, dv, rem_nx, quo_nx, m_new, a_new, tf;
    logic [WIDTH-1:0] seed [NCH];
    logic [CW-1:0] cnt;
    logic [CHW-1:0] rr, ch, gch;
    logic [WIDTH:0] shl;
    logic [2*WIDTH-1:0] p1, p2;
    logic signed [PW-1:0] t;
    logic idle, do_cfg, do_seed, start, start_cont, ge, div_done, cfg_bad, seed_bad;

    assign idle       = state == IDLE;
    assign busy       = !idle;
    assign do_cfg     = idle && cfg_wr;
    assign do_seed    = idle && !cfg_wr && seed_wr;
    assign req_ready  = rst && idle && !cont && !cfg_wr && !seed_wr;
    assign start_cont = idle && cont && !cfg_wr && !seed_wr;
    assign start      = start_cont || (req_ready && req_valid);
    assign gch        = cont ? rr : req_ch;

    assign m_new    = (cfg_m < WIDTH'(2)) ? M_RST : cfg_m;
    assign a_new    = (cfg_a == '0) ? WIDTH'(1) : cfg_a;
    assign cfg_bad  = (cfg_m < WIDTH'(2)) || (cfg_a == '0);
    assign seed_bad = (seed_data == '0) || (seed_data >= m);

    // One restoring step: quo shifts dividend bits out and quotient bits in.
    assign shl      = {rem, quo[WIDTH-1]};
    assign ge       = shl >= {1'b0, dv};
    assign rem_nx   = ge ? WIDTH'(shl - {1'b0, dv}) : shl[WIDTH-1:0];
    assign quo_nx   = {quo[WIDTH-2:0], ge};
    assign div_done = cnt == CW'(WIDTH - 1);

    // After DIV, quo holds hi = s / q and rem holds lo = s % q.
    assign p1 = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, rem};
    assign p2 = {{WIDTH{1'b0}}, r} * {{WIDTH{1'b0}}, quo};
    assign tf = (t[PW-1] || t == '0) ? WIDTH'(t + $signed({{(WIDTH+2){1'b0}}, m})) : t[WIDTH-1:0];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = do_cfg ? CFG_DIV : start ? DIV : IDLE;
            CFG_DIV: state_nx = div_done ? IDLE : CFG_DIV;
            DIV:     state_nx = div_done ? MUL : DIV;
            MUL:     state_nx = FIX;
            FIX:     state_nx = HOLD;
            HOLD:    state_nx = out_ready ? IDLE : HOLD;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m         <= M_RST;
            a         <= A_RST;
            q         <= M_RST / A_RST;
            r         <= M_RST % A_RST;
            for (int i = 0; i < NCH; i++) seed[i] <= WIDTH'(1);
            quo       <= '0;
            rem       <= '0;
            dv        <= WIDTH'(1);
            cnt       <= '0;
            rr        <= '0;
            ch        <= '0;
            t         <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            seed_fix  <= 1'b0;
        end else begin
            if (do_cfg) begin
                m        <= m_new;
                a        <= a_new;
                seed_fix <= cfg_bad;
                quo      <= m_new;
                rem      <= '0;
                dv       <= a_new;
                cnt      <= '0;
            end else if (do_seed) begin
                seed[seed_ch] <= seed_bad ? WIDTH'(1) : seed_data;
                if (seed_bad) seed_fix <= 1'b1;
            end else if (start) begin
                ch  <= gch;
                quo <= seed[gch];
                rem <= '0;
                dv  <= q;
                cnt <= '0;
                if (start_cont) rr <= (rr == CHW'(NCH - 1)) ? '0 : rr + 1'b1;
            end
            if (state == CFG_DIV || state == DIV) begin
                quo <= quo_nx;
                rem <= rem_nx;
                cnt <= cnt + 1'b1;
                if (state == CFG_DIV && div_done) begin
                    q <= quo_nx;
                    r <= rem_nx;
                end
            end
            if (state == MUL) t <= $signed({2'b0, p1}) - $signed({2'b0, p2});
            if (state == FIX) begin
                seed[ch]  <= tf;
                out_data  <= tf;
                out_ch    <= ch;
                out_valid <= 1'b1;
            end
            if (state == HOLD && out_ready) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_prng_lehmer_mc.sv
// tb_prng_lehmer_mc: directed bench for prng_lehmer_mc with an (a*s) mod m
// reference model checked on every cycle a result is presented.
module tb_prng_lehmer_mc;
    localparam int W = 32;

    logic clk = 0, rst = 1;
    logic cfg_wr = 0, seed_wr = 0, cont = 0, req_valid = 0, out_ready = 1;
    logic [W-1:0] cfg_m = 0, cfg_a = 0, seed_data = 0;
    logic [1:0] seed_ch = 0, req_ch = 0;
    logic req_ready, out_valid, busy, seed_fix;
    logic [1:0] out_ch;
    logic [W-1:0] out_data;

    int total = 0, bad = 0;
    longint unsigned mdl_m = 2147483647, mdl_a = 16807;
    longint unsigned mdl_seed [4] = '{1, 1, 1, 1};
    int exp_q [$];
    int e_ch = -1;
    longint unsigned e_data = 0;
    logic prev_v = 0;

    prng_lehmer_mc dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_m(cfg_m), .cfg_a(cfg_a),
        .seed_wr(seed_wr), .seed_ch(seed_ch), .seed_data(seed_data), .cont(cont),
        .req_valid(req_valid), .req_ch(req_ch), .req_ready(req_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out_data(out_data), .busy(busy), .seed_fix(seed_fix)
    );

    always #5 clk = ~clk;

    function automatic longint unsigned nxt(input longint unsigned s);
        return (mdl_a * s) % mdl_m;
    endfunction

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Every presented result must match the model for the channel the bench expects next.
    always @(negedge clk) begin
        if (out_valid) begin
            if (!prev_v) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                    e_ch = -1;
                end else begin
                    e_ch = exp_q.pop_front();
                    e_data = nxt(mdl_seed[e_ch]);
                    mdl_seed[e_ch] = e_data;
                end
            end
            if (e_ch >= 0) begin
                chk("res_ch", out_ch, longint'(e_ch));
                chk("res_data", out_data, e_data);
                chk("res_range", longint'(out_data >= 1 && out_data < mdl_m), 1);
                chk("hold_req_ready", req_ready, 0);
            end
        end
        prev_v = out_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic seed_w(input int c, input longint unsigned v);
        seed_wr = 1;
        seed_ch = 2'(c);
        seed_data = W'(v);
        tick();
        seed_wr = 0;
        mdl_seed[c] = (v == 0 || v >= mdl_m) ? 1 : v;
    endtask

    task automatic cfg_w(input longint unsigned mm, input longint unsigned aa, output int n);
        cfg_wr = 1;
        cfg_m = W'(mm);
        cfg_a = W'(aa);
        tick();
        cfg_wr = 0;
        mdl_m = (mm < 2) ? 2147483647 : mm;
        mdl_a = (aa == 0) ? 1 : aa;
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic do_req(input int c, output int lat, output longint unsigned d, output int oc);
        int k = 0;
        while (!req_ready && k < 200) begin
            k++;
            tick();
        end
        chk("req_ready_wait", req_ready, 1);
        req_valid = 1;
        req_ch = 2'(c);
        exp_q.push_back(c);
        tick();
        req_valid = 0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            lat++;
            tick();
        end
        d = out_data;
        oc = int'(out_ch);
        if (out_ready) tick();
    endtask

    task automatic wait_res(output longint unsigned d, output int oc);
        int k = 0;
        while (!out_valid && k < 200) begin
            k++;
            tick();
        end
        chk("wait_res_timeout", out_valid, 1);
        d = out_data;
        oc = int'(out_ch);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, oc, n;
        longint unsigned d, s, d0;
        int oc0;
        longint unsigned cont_exp [4] = '{84035, 117649, 151263, 184877};
        #1 rst = 0;
        tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_seed_fix", seed_fix, 0);
        rst = 1;
        tick();
        // request mode, ch0 from seed 1
        seed_w(0, 1);
        do_req(0, lat, d, oc);
        chk("t1_lat0", lat, 34); chk("t1_d0", d, 16807); chk("t1_ch0", oc, 0);
        do_req(0, lat, d, oc);
        chk("t1_lat1", lat, 34); chk("t1_d1", d, 282475249);
        do_req(0, lat, d, oc);
        chk("t1_lat2", lat, 34); chk("t1_d2", d, 1622650073);
        // continuous round-robin
        seed_w(0, 5); seed_w(1, 7); seed_w(2, 9); seed_w(3, 11);
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        exp_q.push_back(0);
        cont = 1;
        #1 chk("cont_req_ready", req_ready, 0);
        for (int i = 0; i < 4; i++) begin
            wait_res(d, oc);
            chk("t2_ch", oc, i);
            chk("t2_data", d, cont_exp[i]);
        end
        tick();
        cont = 0;
        wait_res(d, oc);
        chk("t2_wrap_ch", oc, 0);
        chk("t2_wrap_data", d, 1412376245);
        // jump ch2 to the 9999th state; the 10000th is the classic check value
        s = 1;
        for (int i = 0; i < 9999; i++) s = nxt(s);
        seed_w(2, s);
        do_req(2, lat, d, oc);
        chk("t3_10000th", d, 1043618065);
        do_req(1, lat, d, oc);
        chk("t3_ch1_untouched", d, 1977326743);
        do_req(3, lat, d, oc);
        // new multiplier
        cfg_w(2147483647, 48271, n);
        chk("t4_cfg_busy", n, 32);
        chk("t4_seed_fix", seed_fix, 0);
        seed_w(1, 1);
        do_req(1, lat, d, oc);
        chk("t4_d0", d, 48271);
        do_req(1, lat, d, oc);
        chk("t4_d1", d, 182605794);
        // backpressure
        out_ready = 0;
        do_req(0, lat, d0, oc0);
        req_valid = 1;
        req_ch = 2'd1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, d0);
            chk("bp_ch", out_ch, longint'(oc0));
            chk("bp_req_ready", req_ready, 0);
        end
        req_valid = 0;
        out_ready = 1;
        tick();
        chk("bp_consumed", out_valid, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_no_repeat", out_valid, 0);
        end
        // asynchronous reset mid-DIV
        while (!req_ready) tick();
        req_valid = 1;
        req_ch = 2'd0;
        exp_q.push_back(0);
        tick();
        req_valid = 0;
        repeat (10) tick();
        chk("ar_busy_before", busy, 1);
        #2 rst = 0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_out_data", out_data, 0);
        chk("ar_out_valid", out_valid, 0);
        chk("ar_req_ready", req_ready, 0);
        exp_q.delete();
        mdl_m = 2147483647;
        mdl_a = 16807;
        for (int i = 0; i < 4; i++) mdl_seed[i] = 1;
        tick();
        tick();
        rst = 1;
        tick();
        do_req(2, lat, d, oc);
        chk("ar_seed_back_to_1", d, 16807);
        // illegal seeds
        seed_w(3, 0);
        chk("sf_zero_flag", seed_fix, 1);
        do_req(3, lat, d, oc);
        chk("sf_zero_out", d, 16807);
        cfg_w(2147483647, 16807, n);
        chk("sf_cleared", seed_fix, 0);
        seed_w(3, 2147483647);
        chk("sf_m_flag", seed_fix, 1);
        do_req(3, lat, d, oc);
        chk("sf_m_out", d, 16807);
        // illegal configuration: m<2 -> M_RST, a=0 -> 1, so output equals seed
        cfg_w(1, 0, n);
        chk("ic_busy", n, 32);
        chk("ic_flag", seed_fix, 1);
        seed_w(0, 12345);
        do_req(0, lat, d, oc);
        chk("ic_a1_out", d, 12345);
        repeat (3) tick();
        chk("end_queue_empty", longint'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
